brushless_comm: RTL and testbench
=================================

Name: brushless_comm

Overview:
- Commutation controller that drives the three-coil motor-driver interface from the other end.
- Samples the three hall sensors and the brake request, and produces the per-coil select codes (selGrn/selYlw/selBlu) and the 11-bit PWM duty that the motor driver consumes.
- Updates rotor state only at the motor driver's PWM period boundary (PWM_synch), so coil drive never changes mid-period.
- Adds hall-fault detection and a commutation counter for speed telemetry.

Parameters:
- FAULT_CNT, 4: consecutive invalid hall samples (taken at PWM_synch) before hall_fault asserts; legal range 1..15.
- DUTY_BRK, 11'h600: duty driven while braking.
- DUTY_BASE, 11'h400: duty offset added to the scaled drive magnitude.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- hallGrn  in  1  green hall sensor, asynchronous.
- hallYlw  in  1  yellow hall sensor, asynchronous.
- hallBlu  in  1  blue hall sensor, asynchronous.
- brake_n  in  1  brake request, active low, asynchronous.
- drv_mag  in  12  unsigned drive magnitude from the torque loop.
- PWM_synch  in  1  one-clk pulse at each PWM period start, from the motor driver.
- selGrn  out  2  green coil select: 00 coast (hi-Z), 01 forward, 10 reverse, 11 dynamic brake.
- selYlw  out  2  yellow coil select, same encoding.
- selBlu  out  2  blue coil select, same encoding.
- duty  out  11  PWM duty to the motor driver.
- hall_fault  out  1  sticky-until-valid invalid-hall indicator.
- comm_cnt  out  16  count of valid commutation steps; wraps modulo 2^16.

Behaviour:
- Reset is synchronous: on any rising clk edge with rst_n==0, the following clear regardless of other inputs, including mid-PWM-period:
  - all sync flops; hall flops clear to 0; brake flops set to 1 (not braking);
  - rot_state = 3'b000, fault_cnt = 0, hall_fault = 0, comm_cnt = 0;
  - sel* = 00, duty = 0.
- Synchronization: hallGrn, hallYlw, hallBlu and brake_n each pass through a 2-flop synchronizer. The synced values are hall_s[2:0] = {Grn, Ylw, Blu} and brk_s.
- rot_state capture:
  - Loads hall_s only on a clk edge where PWM_synch==1; otherwise it holds.
  - An input hall change therefore appears at rot_state no earlier than 3 clks later, and only at the next PWM_synch.
- Commutation table, rot_state -> {selGrn, selYlw, selBlu}:
  - 101 -> 10, 01, 00
  - 100 -> 10, 00, 01
  - 110 -> 00, 10, 01
  - 010 -> 01, 10, 00
  - 011 -> 01, 00, 10
  - 001 -> 00, 01, 10
  - 000 and 111 (invalid) -> 00, 00, 00
- Outputs are registered: sel* and duty update on the clk edge after rot_state or brk_s changes, a 1-clk latency.
- Priority for sel*, highest first:
  1. brk_s==0: all three selects = 11, whatever the fault or hall state.
  2. hall_fault==1: all 00.
  3. Otherwise the commutation table.
- Duty:
  - Braking: duty = DUTY_BRK.
  - Fault and not braking: duty = 0.
  - Otherwise: duty = DUTY_BASE + {1'b0, drv_mag[11:2]}, an 11-bit add.
    - Maximum is 0x400 + 0x3FF = 0x7FF, so there is no overflow and no saturation logic.
  - duty recomputes every clk, not only at PWM_synch.
- Fault detection, evaluated only on PWM_synch edges:
  - Invalid sample: fault_cnt increments, saturating at FAULT_CNT; hall_fault = 1 once fault_cnt reaches FAULT_CNT.
  - Valid sample: fault_cnt = 0 and hall_fault = 0 on that same edge.
- comm_cnt:
  - Increments by 1 on a PWM_synch edge where the new hall_s is valid, the old rot_state is valid, and they differ.
  - No increment on a transition from or to an invalid state, or on a repeated state.
  - 0xFFFF + 1 wraps to 0x0000.
- Simultaneous events:
  - A hall change coinciding with PWM_synch is captured per the synced value present at that edge.
  - Brake assertion takes effect within 3 clks (2 sync + 1 output register), independent of PWM_synch.
  - On brake release, sel* resumes the table or fault value from the current rot_state on the next clk.

Test Plan:
- Reset, then rst_n high with halls = 101 and brake_n = 1, pulse PWM_synch -> 1 clk after capture, sel = {10, 01, 00}; drv_mag = 12'hFFF gives duty = 11'h7FF.
- Step the halls through 101, 100, 110, 010, 011, 001, 101, one change per PWM period -> sel follows the table each step; comm_cnt = 6; halls changing between PWM_synch pulses cause no sel change.
- Halls = 000 for 3 PWM periods, then a 4th (FAULT_CNT = 4) -> hall_fault = 0 after 3 samples and 1 after the 4th; sel = all 00; duty = 0. A valid sample then clears the fault and restores the table.
- brake_n = 0 mid-period with halls valid, and also while hall_fault = 1 -> within 3 clks sel = {11, 11, 11} and duty = 11'h600; release restores the prior outputs.
- Preload comm_cnt to 0xFFFF via a long run (or force), then one valid commutation -> comm_cnt = 0x0000.
- Assert rst_n = 0 for 1 clk mid-operation while braking -> next edge: all outputs 0, hall_fault = 0; no output change while rst_n is high and no clk edge occurs (synchronous reset only).

Source files
------------

// File: rtl/brushless_comm.sv
// Three-coil commutation controller: synchronizes halls/brake, latches rotor
// state on each PWM period start, and drives registered coil selects and duty.
module brushless_comm #(
    parameter int unsigned FAULT_CNT = 4,
    parameter logic [10:0] DUTY_BRK  = 11'h600,
    parameter logic [10:0] DUTY_BASE = 11'h400
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hallGrn,
    input  logic        hallYlw,
    input  logic        hallBlu,
    input  logic        brake_n,
    input  logic [11:0] drv_mag,
    input  logic        PWM_synch,
    output logic [1:0]  selGrn,
    output logic [1:0]  selYlw,
    output logic [1:0]  selBlu,
    output logic [10:0] duty,
    output logic        hall_fault,
    output logic [15:0] comm_cnt
);

    localparam logic [3:0] FAULT_MAX = 4'(FAULT_CNT);

    logic [2:0]  hall_s1_q, hall_s2_q;
    logic        brk_s1_q, brk_s2_q;
    logic [2:0]  rot_q, rot_d;
    logic [3:0]  fcnt_q, fcnt_d;
    logic        fault_q, fault_d;
    logic [15:0] comm_cnt_q, comm_cnt_d;
    logic [5:0]  sel_q, sel_d, sel_tbl;
    logic [10:0] duty_q, duty_d;
    logic        hall_ok, rot_ok;

    assign hall_ok = (hall_s2_q != 3'b000) && (hall_s2_q != 3'b111);
    assign rot_ok  = (rot_q != 3'b000) && (rot_q != 3'b111);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hall_s1_q  <= '0;
            hall_s2_q  <= '0;
            brk_s1_q   <= 1'b1;
            brk_s2_q   <= 1'b1;
            rot_q      <= '0;
            fcnt_q     <= '0;
            fault_q    <= 1'b0;
            comm_cnt_q <= '0;
            sel_q      <= '0;
            duty_q     <= '0;
        end else begin
            hall_s1_q  <= {hallGrn, hallYlw, hallBlu};
            hall_s2_q  <= hall_s1_q;
            brk_s1_q   <= brake_n;
            brk_s2_q   <= brk_s1_q;
            rot_q      <= rot_d;
            fcnt_q     <= fcnt_d;
            fault_q    <= fault_d;
            comm_cnt_q <= comm_cnt_d;
            sel_q      <= sel_d;
            duty_q     <= duty_d;
        end
    end

    // Rotor state, fault tracking and step counting only advance at PWM period start.
    always_comb begin
        rot_d      = rot_q;
        fcnt_d     = fcnt_q;
        fault_d    = fault_q;
        comm_cnt_d = comm_cnt_q;
        if (PWM_synch) begin
            rot_d = hall_s2_q;
            if (hall_ok) begin
                fcnt_d  = '0;
                fault_d = 1'b0;
                if (rot_ok && (hall_s2_q != rot_q))
                    comm_cnt_d = comm_cnt_q + 16'd1;
            end else begin
                if (fcnt_q < FAULT_MAX)
                    fcnt_d = fcnt_q + 4'd1;
                fault_d = (fcnt_d == FAULT_MAX);
            end
        end
    end

    always_comb begin
        case (rot_q)
            3'b101:  sel_tbl = 6'b10_01_00;
            3'b100:  sel_tbl = 6'b10_00_01;
            3'b110:  sel_tbl = 6'b00_10_01;
            3'b010:  sel_tbl = 6'b01_10_00;
            3'b011:  sel_tbl = 6'b01_00_10;
            3'b001:  sel_tbl = 6'b00_01_10;
            default: sel_tbl = 6'b00_00_00;
        endcase
    end

    always_comb begin
        sel_d  = sel_tbl;
        duty_d = 11'(DUTY_BASE + (drv_mag >> 2));
        if (!brk_s2_q) begin
            sel_d  = '1;
            duty_d = DUTY_BRK;
        end else if (fault_q) begin
            sel_d  = '0;
            duty_d = '0;
        end
    end

    assign selGrn     = sel_q[5:4];
    assign selYlw     = sel_q[3:2];
    assign selBlu     = sel_q[1:0];
    assign duty       = duty_q;
    assign hall_fault = fault_q;
    assign comm_cnt   = comm_cnt_q;

endmodule

// File: tb/tb_brushless_comm.sv
// Directed plus randomized bench for brushless_comm against a behavioural
// model of rotor capture, fault counting, commutation counting and drive priority.
module tb_brushless_comm;

    localparam int FAULT_N = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        hallGrn = 1'b0, hallYlw = 1'b0, hallBlu = 1'b0;
    logic        brake_n = 1'b1;
    logic [11:0] drv_mag = '0;
    logic        PWM_synch = 1'b0;
    logic [1:0]  selGrn, selYlw, selBlu;
    logic [10:0] duty;
    logic        hall_fault;
    logic [15:0] comm_cnt;

    brushless_comm #(.FAULT_CNT(FAULT_N), .DUTY_BRK(11'h600), .DUTY_BASE(11'h400)) dut (
        .clk(clk), .rst_n(rst_n),
        .hallGrn(hallGrn), .hallYlw(hallYlw), .hallBlu(hallBlu),
        .brake_n(brake_n), .drv_mag(drv_mag), .PWM_synch(PWM_synch),
        .selGrn(selGrn), .selYlw(selYlw), .selBlu(selBlu),
        .duty(duty), .hall_fault(hall_fault), .comm_cnt(comm_cnt)
    );

    always #5 clk = ~clk;

    // Coil drive per captured hall code, indexed by {Grn,Ylw,Blu}.
    logic [5:0] tbl [8] = '{6'b00_00_00, 6'b00_01_10, 6'b01_10_00, 6'b01_00_10,
                            6'b10_00_01, 6'b10_01_00, 6'b00_10_01, 6'b00_00_00};

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [2:0]  m_rot;
    int          m_fcnt;
    logic        m_fault;
    logic [15:0] m_cnt;
    logic        m_brk_n;
    logic [11:0] m_mag;

    function automatic bit valid_code(input logic [2:0] h);
        return (h != 3'd0) && (h != 3'd7);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        m_rot = 3'd0; m_fcnt = 0; m_fault = 1'b0; m_cnt = 16'd0;
    endtask

    task automatic model_capture(input logic [2:0] h);
        if (valid_code(h)) begin
            if (valid_code(m_rot) && h != m_rot) m_cnt = m_cnt + 16'd1;
            m_fcnt  = 0;
            m_fault = 1'b0;
        end else begin
            m_fcnt  = (m_fcnt + 1 > FAULT_N) ? FAULT_N : m_fcnt + 1;
            m_fault = (m_fcnt == FAULT_N);
        end
        m_rot = h;
    endtask

    task automatic check_all(input string tag);
        logic [5:0]  e_sel;
        logic [10:0] e_duty;
        if (!m_brk_n) begin
            e_sel = 6'b11_11_11; e_duty = 11'h600;
        end else if (m_fault) begin
            e_sel = 6'd0; e_duty = 11'd0;
        end else begin
            e_sel = tbl[m_rot]; e_duty = 11'h400 + 11'(m_mag / 4);
        end
        chk({tag, ".sel"},   32'({selGrn, selYlw, selBlu}), 32'(e_sel));
        chk({tag, ".duty"},  32'(duty), 32'(e_duty));
        chk({tag, ".fault"}, 32'(hall_fault), 32'(m_fault));
        chk({tag, ".cnt"},   32'(comm_cnt), 32'(m_cnt));
    endtask

    // Drive inputs, let them settle through the synchronizers, then one PWM_synch pulse.
    task automatic period(input string tag, input logic [2:0] h, input logic brk, input logic [11:0] mag);
        @(negedge clk);
        {hallGrn, hallYlw, hallBlu} = h;
        brake_n = brk;
        drv_mag = mag;
        repeat (3) @(negedge clk);
        PWM_synch = 1'b1;
        @(negedge clk);
        PWM_synch = 1'b0;
        m_brk_n = brk;
        m_mag   = mag;
        model_capture(h);
        @(negedge clk);
        check_all(tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit exceeded");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] steps [6] = '{3'b100, 3'b110, 3'b010, 3'b011, 3'b001, 3'b101};
        logic [2:0] h;
        logic       b;

        model_reset();
        m_brk_n = 1'b1;
        m_mag   = '0;
        repeat (2) @(negedge clk);
        chk("reset.sel",   32'({selGrn, selYlw, selBlu}), 32'd0);
        chk("reset.duty",  32'(duty), 32'd0);
        chk("reset.fault", 32'(hall_fault), 32'd0);
        chk("reset.cnt",   32'(comm_cnt), 32'd0);
        rst_n = 1'b1;

        period("first", 3'b101, 1'b1, 12'hFFF);
        chk("first.duty_max", 32'(duty), 32'h7FF);

        foreach (steps[i]) period("step", steps[i], 1'b1, 12'($urandom_range(0, 4095)));
        chk("step.cnt6", 32'(comm_cnt), 32'd6);

        // Hall change without PWM_synch must not reach the coils.
        {hallGrn, hallYlw, hallBlu} = 3'b100;
        repeat (6) @(negedge clk);
        check_all("midper");
        period("midper_cap", 3'b100, 1'b1, 12'h123);

        for (int k = 0; k < FAULT_N; k++) period("fault", 3'b000, 1'b1, 12'h800);
        chk("fault.set", 32'(hall_fault), 32'd1);
        period("fault_clr", 3'b110, 1'b1, 12'h456);

        // Brake mid-period: two sync flops plus output register.
        @(negedge clk);
        brake_n = 1'b0;
        repeat (2) @(negedge clk);
        check_all("brk_pre");
        @(negedge clk);
        m_brk_n = 1'b0;
        check_all("brk_on");
        brake_n = 1'b1;
        repeat (3) @(negedge clk);
        m_brk_n = 1'b1;
        check_all("brk_off");

        for (int k = 0; k < FAULT_N; k++) period("fault7", 3'b111, 1'b1, 12'h321);
        @(negedge clk);
        brake_n = 1'b0;
        repeat (3) @(negedge clk);
        m_brk_n = 1'b0;
        check_all("brk_fault_on");
        brake_n = 1'b1;
        repeat (3) @(negedge clk);
        m_brk_n = 1'b1;
        check_all("brk_fault_off");

        for (int k = 0; k < 40; k++) begin
            h = 3'($urandom_range(0, 7));
            b = ($urandom_range(0, 4) != 0);
            period("rand", h, b, 12'($urandom_range(0, 4095)));
        end

        period("pre_wrap", 3'b011, 1'b1, 12'h010);
        @(negedge clk);
        force dut.comm_cnt_q = 16'hFFFF;
        @(negedge clk);
        release dut.comm_cnt_q;
        m_cnt = 16'hFFFF;
        chk("wrap.preload", 32'(comm_cnt), 32'hFFFF);
        period("wrap", 3'b001, 1'b1, 12'h020);
        chk("wrap.zero", 32'(comm_cnt), 32'h0000);

        // Reset is synchronous: nothing moves until the next rising edge.
        @(negedge clk);
        brake_n = 1'b0;
        repeat (4) @(negedge clk);
        m_brk_n = 1'b0;
        check_all("rst_brk");
        rst_n = 1'b0;
        #2;
        check_all("rst_hold");
        @(negedge clk);
        chk("rst2.sel",   32'({selGrn, selYlw, selBlu}), 32'd0);
        chk("rst2.duty",  32'(duty), 32'd0);
        chk("rst2.fault", 32'(hall_fault), 32'd0);
        chk("rst2.cnt",   32'(comm_cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
